ssd_capture: RTL

Receive-side counterpart of the seven-segment encoder. Samples a time-multiplexed 4-digit seven-segment bus (active-low segments, active-low anodes), waits for each digit to hold stable, inverse-decodes the segment pattern back to a 4-bit hex nibble, and assembles a 16-bit value plus a frame strobe. Used as an on-board loopback monitor, checking that the display path shows the datapath value it was given.

---
 rtl/ssd_pkg.sv | 24 ++
 rtl/ssd_capture_if.sv | 22 ++
 rtl/ssd_pattern_decode.sv | 19 +
 rtl/ssd_capture.sv | 95 +++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared seven-segment definitions for the encoder and the capture monitor.
// Segment bits are active-low, ordered bit6=a .. bit0=g.
package ssd_pkg;
  localparam int SEG_W  = 7;
  localparam int DIGITS = 4;
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  // Index of the single set bit of a one-hot digit select.
  function automatic logic [1:0] onehot_idx(input logic [DIGITS-1:0] sel);
    return {sel[3] | sel[2], sel[3] | sel[1]};
  endfunction
endpackage

// File: rtl/ssd_capture_if.sv
// ssd_capture_if: display bus plus monitor results.
// master drives seg_in/an_in/clr and observes results; slave is the capture block.
interface ssd_capture_if;
  import ssd_pkg::*;
  logic [SEG_W-1:0]  seg_in;
  logic [DIGITS-1:0] an_in;
  logic              clr;
  logic [15:0]       value;
  logic [DIGITS-1:0] digit_valid;
  logic [15:0]       frame_value;
  logic              frame_valid;
  logic              pattern_err;
  logic [1:0]        err_digit;
  modport master (
    output seg_in, an_in, clr,
    input  value, digit_valid, frame_value, frame_valid, pattern_err, err_digit
  );
  modport slave (
    input  seg_in, an_in, clr,
    output value, digit_valid, frame_value, frame_valid, pattern_err, err_digit
  );
endinterface

// File: rtl/ssd_pattern_decode.sv
// ssd_pattern_decode: inverse seven-segment lookup.
// i_seg: active-low pattern; o_nibble: hex value; o_legal: pattern is one of the 16 encodings.
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic [3:0]       o_nibble,
  output logic             o_legal
);
  always_comb begin
    o_nibble = '0;
    o_legal  = 1'b0;
    for (int i = 0; i < 16; i++)
      if (i_seg == SEG_TABLE[i]) begin
        o_nibble = 4'(i);
        o_legal  = 1'b1;
      end
  end
endmodule

// File: rtl/ssd_capture.sv
// ssd_capture: samples a multiplexed 4-digit seven-segment bus and rebuilds the shown value.
// clk/rst_n: clock, async active-low reset; bus: slave side of ssd_capture_if
// (seg_in, an_in, clr in; value, digit_valid, frame_value, frame_valid, pattern_err, err_digit out).
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input logic         clk,
  input logic         rst_n,
  ssd_capture_if.slave bus
);
  logic [10:0]       r_prev;
  logic [7:0]        r_cnt;
  logic [15:0]       r_value;
  logic [15:0]       r_frame_value;
  logic [DIGITS-1:0] r_valid;
  logic [DIGITS-1:0] r_seen;
  logic              r_pend;
  logic              r_frame_valid;
  logic              r_err;
  logic [1:0]        r_err_digit;
  logic [10:0]       w_in;
  logic              w_same;
  logic [DIGITS-1:0] w_sel;
  logic              w_onehot;
  logic              w_commit;
  logic [1:0]        w_idx;
  logic [DIGITS-1:0] w_bit;
  logic [3:0]        w_nibble;
  logic              w_legal;
  logic [DIGITS-1:0] w_valid_base;
  logic [DIGITS-1:0] w_seen_base;
  logic [DIGITS-1:0] w_valid_next;
  logic [DIGITS-1:0] w_seen_next;
  logic [15:0]       w_value_next;
  logic              w_frame;
  logic [4:0]        w_sh;

  ssd_pattern_decode u_dec (.i_seg(bus.seg_in), .o_nibble(w_nibble), .o_legal(w_legal));

  assign w_in     = {bus.an_in, bus.seg_in};
  assign w_same   = w_in == r_prev;
  assign w_sel    = ~bus.an_in;
  assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - 4'd1)) == '0);
  // w_same guards against a stale count from the previous run matching on the first new cycle.
  assign w_commit = w_onehot && (bus.seg_in != SEG_BLANK) && w_same
                    && (r_cnt == 8'(STABLE_CYCLES - 2));
  assign w_idx    = onehot_idx(w_sel);
  assign w_bit    = 4'b0001 << w_idx;
  assign w_sh     = {1'b0, w_idx, 2'b00};

  // clr applies first; a same-cycle commit then overrides its own digit's bits.
  always_comb begin
    w_valid_base = bus.clr ? '0 : r_valid;
    w_seen_base  = bus.clr ? '0 : r_seen;
    w_valid_next = !w_commit ? w_valid_base : w_legal ? (w_valid_base | w_bit) : (w_valid_base & ~w_bit);
    w_seen_next  = !w_commit ? w_seen_base  : w_legal ? (w_seen_base | w_bit)  : (w_seen_base & ~w_bit);
    w_value_next = (w_commit && w_legal) ? ((r_value & ~(16'hF << w_sh)) | (16'(w_nibble) << w_sh)) : r_value;
    w_frame      = w_seen_next == 4'hF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev        <= 11'h7FF;
      r_cnt         <= '0;
      r_value       <= '0;
      r_frame_value <= '0;
      r_valid       <= '0;
      r_seen        <= '0;
      r_pend        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
      r_err_digit   <= '0;
    end else begin
      r_prev        <= w_in;
      r_cnt         <= !w_same ? 8'd0 : (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
      r_value       <= w_value_next;
      r_valid       <= w_valid_next;
      r_seen        <= w_frame ? '0 : w_seen_next;
      r_pend        <= w_frame;
      r_frame_valid <= r_pend;
      if (r_pend) r_frame_value <= r_value;
      r_err         <= (w_commit && !w_legal) || (r_err && !bus.clr);
      if (w_commit && !w_legal) r_err_digit <= w_idx;
    end
  end

  assign bus.value       = r_value;
  assign bus.digit_valid = r_valid;
  assign bus.frame_value = r_frame_value;
  assign bus.frame_valid = r_frame_valid;
  assign bus.pattern_err = r_err;
  assign bus.err_digit   = r_err_digit;
endmodule
